// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue gate between decode and execute: tracks pending
// long-latency destinations, stalls on RAW/WAW/pool-full/FENCE drain, keeps stall stats.
module issue_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_dec_valid,
  output logic             o_dec_ready,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [4:0]       i_rd,
  input  logic             i_rs1_used,
  input  logic             i_rs2_used,
  input  logic             i_rd_wr,
  input  logic             i_long_lat,
  input  logic             i_fence,
  input  logic             i_flush,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  output logic             o_issue,
  output logic [31:0]      o_busy,
  output logic [CNT_W-1:0] o_outstanding,
  output logic [31:0]      o_stall_cnt,
  output logic             o_wb_err
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        stall_q, stall_d;
  logic               wb_err_q, wb_err_d;

  logic haz_rs1, haz_rs2, haz_waw, pool_full, fence_blk;
  logic set_en, clr_en, stall_ev;

  // A same-cycle writeback to the register in question removes the hazard.
  always_comb begin
    haz_rs1   = i_rs1_used && (i_rs1 != 5'd0) && busy_q[i_rs1] &&
                !(i_wb_valid && (i_wb_rd == i_rs1));
    haz_rs2   = i_rs2_used && (i_rs2 != 5'd0) && busy_q[i_rs2] &&
                !(i_wb_valid && (i_wb_rd == i_rs2));
    haz_waw   = i_rd_wr && i_long_lat && (i_rd != 5'd0) && busy_q[i_rd] &&
                !(i_wb_valid && (i_wb_rd == i_rd));
    pool_full = i_long_lat && (cnt_q == CNT_W'(MAX_OUTSTANDING));
    fence_blk = i_fence && (cnt_q != '0);

    o_dec_ready = (state_q == RUN) && !haz_rs1 && !haz_rs2 && !haz_waw &&
                  !pool_full && !fence_blk;
    o_issue     = i_dec_valid && o_dec_ready && !i_flush;
    stall_ev    = i_dec_valid && !o_dec_ready && !i_flush;

    set_en = o_issue && i_long_lat && i_rd_wr && (i_rd != 5'd0);
    clr_en = i_wb_valid && (i_wb_rd != 5'd0) && busy_q[i_wb_rd];
  end

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    wb_err_d = wb_err_q;
    state_d  = state_q;

    // Clear first so a same-cycle set of the same register wins.
    if (clr_en) busy_d[i_wb_rd] = 1'b0;
    if (set_en) busy_d[i_rd]    = 1'b1;
    cnt_d = cnt_q + CNT_W'(set_en) - CNT_W'(clr_en);

    if (i_wb_valid && (i_wb_rd != 5'd0) && !busy_q[i_wb_rd]) wb_err_d = 1'b1;
    if (stall_ev && (stall_q != '1)) stall_d = stall_q + 32'd1;

    case (state_q)
      RUN:   if (i_dec_valid && i_fence && (cnt_q != '0) && !i_flush) state_d = DRAIN;
      DRAIN: if (i_flush || (cnt_q == '0)) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= RUN;
      busy_q   <= '0;
      cnt_q    <= '0;
      stall_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign o_busy        = {busy_q[31:1], 1'b0};
  assign o_outstanding = cnt_q;
  assign o_stall_cnt   = stall_q;
  assign o_wb_err      = wb_err_q;

endmodule
